// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage: S1 holds a beat while its round key is read,
// OUT holds state ^ key on a valid/ready output.
module ark_lane #(
    parameter int VEC_W = 8
) (
    input  logic [VEC_W-1:0] a,
    input  logic [VEC_W-1:0] b,
    output logic [VEC_W-1:0] y
);
    assign y = a ^ b;
endmodule

module add_round_key_stage #(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_state,
    input  logic           in_first,
    output logic [RKW-1:0] rk_addr,
    input  logic [127:0]   rk_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_state,
    output logic [RKW-1:0] out_round,
    output logic           out_last
);
    localparam int NUM_LANES = 16;
    localparam int VEC_W     = 8;
    localparam logic [RKW-1:0] LAST_RND = RKW'(NR);

    typedef struct packed {
        logic [NUM_LANES-1:0][VEC_W-1:0] state;
        logic [RKW-1:0]                  round;
    } beat_t;

    beat_t                           s1_q;
    logic                            s1_valid;
    logic [RKW-1:0]                  rc;
    logic [RKW-1:0]                  beat_round;
    logic                            in_fire;
    logic                            s1_adv;
    logic [NUM_LANES-1:0][VEC_W-1:0] rk_lanes;
    logic [NUM_LANES-1:0][VEC_W-1:0] xor_res;

    assign beat_round = in_first ? '0 : rc;
    assign s1_adv     = s1_valid & (~out_valid | out_ready);
    assign in_ready   = ~rst & (~s1_valid | s1_adv);
    assign in_fire    = in_valid & in_ready;
    // Hold the address on S1's round while it stalls so rk_data stays matched.
    assign rk_addr    = rst ? '0 : (in_fire ? beat_round : s1_q.round);
    assign rk_lanes   = rk_data;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ark_lane #(.VEC_W(VEC_W)) u_lane (
            .a (s1_q.state[g]),
            .b (rk_lanes[g]),
            .y (xor_res[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            rc        <= '0;
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_q.state <= in_state;
                s1_q.round <= beat_round;
                rc         <= (beat_round == LAST_RND) ? '0 : beat_round + 1'b1;
            end
            s1_valid  <= in_fire | (s1_valid & ~s1_adv);
            out_valid <= s1_adv | (out_valid & ~out_ready);
            if (s1_adv) begin
                out_state <= xor_res;
                out_round <= s1_q.round;
                out_last  <= (s1_q.round == LAST_RND);
            end
        end
    end
endmodule

// File: tb/tb_add_round_key_stage.sv
// Randomized bench for add_round_key_stage against a queue-based model
// of accepted beats and a synchronous-read key memory.
module tb_add_round_key_stage;
    localparam int NR  = 10;
    localparam int RKW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_first, out_ready;
    logic           in_ready, out_valid, out_last;
    logic [127:0]   in_state, rk_data, out_state;
    logic [RKW-1:0] rk_addr, out_round;

    add_round_key_stage #(.NR(NR), .RKW(RKW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_first(in_first),
        .rk_addr(rk_addr), .rk_data(rk_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_last(out_last)
    );

    always #5 clk = ~clk;

    logic [127:0] rk_mem [16];
    always @(posedge clk) rk_data <= rk_mem[rk_addr];

    typedef struct {
        logic [127:0] st;
        int           rnd;
        logic         last;
    } exp_t;

    exp_t q[$];
    int   rc_m = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_fire = 0;
    logic last_fire, last_ofire;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Listed FIPS byte 0 first -> byte 0 at bits [7:0].
    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = v[8*(15-k) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: observe and model at negedge, then advance to just after posedge.
    task automatic cyc();
        exp_t e;
        int   r;
        @(negedge clk);
        last_fire  = 1'b0;
        last_ofire = 1'b0;
        if (rst) begin
            chk("rst_in_ready", 128'(in_ready), 128'd0);
            chk("rst_rk_addr", 128'(rk_addr), 128'd0);
            q.delete();
            rc_m = 0;
        end else begin
            if (in_valid && in_ready) begin
                r = in_first ? 0 : rc_m;
                chk("rk_addr", 128'(rk_addr), 128'(r));
                e.st   = in_state ^ rk_mem[r];
                e.rnd  = r;
                e.last = (r == NR);
                q.push_back(e);
                rc_m = (r == NR) ? 0 : r + 1;
                last_fire = 1'b1;
                n_fire++;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 128'(out_valid), 128'd0);
                end else begin
                    chk("out_state", out_state, q[0].st);
                    chk("out_round", 128'(out_round), 128'(q[0].rnd));
                    chk("out_last", 128'(out_last), 128'(q[0].last));
                    if (out_ready) begin
                        void'(q.pop_front());
                        last_ofire = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("drain_empty", 128'(q.size()), 128'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rk_mem[i] = rnd128();
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0; in_state = '0;
        @(posedge clk); #1;
        cyc(); cyc();
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_state", out_state, 128'd0);
        chk("reset_out_round", 128'(out_round), 128'd0);
        chk("reset_out_last", 128'(out_last), 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd0);
        rst = 1'b0;

        // FIPS-197 App.B round 1, result parked in OUT for a direct look
        rk_mem[1] = bswap(128'ha0fafe1788542cb123a339392a6c7605);
        in_valid = 1'b1; in_first = 1'b1; in_state = rnd128(); cyc();
        in_first = 1'b0; in_state = bswap(128'h046681e5e0cb199a48f8d37a2806264c); cyc();
        in_valid = 1'b0; cyc();
        out_ready = 1'b1; cyc();
        chk("fips_valid", 128'(out_valid), 128'd1);
        chk("fips_state", out_state, bswap(128'ha49c7ff2689f352b6b5bea43026a5049));
        chk("fips_round", 128'(out_round), 128'd1);
        drain();

        // Full block back-to-back: out_valid from t+2, out_last only on round NR
        for (int i = 0; i <= 12; i++) begin
            in_valid = (i <= NR); in_first = (i == 0); in_state = rnd128(); out_ready = 1'b1;
            cyc();
            chk("blk_lat", 128'(out_valid), 128'(i >= 1 && i <= NR + 1));
            chk("blk_last", 128'(out_last && out_valid), 128'(i == NR + 1));
        end
        in_valid = 1'b1; in_first = 1'b0; in_state = rnd128(); cyc();
        chk("wrap_round0", 128'(q[q.size()-1].rnd), 128'd0);
        drain();

        // Backpressure: only two beats fit
        n_fire = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_state = rnd128(); cyc();
        end
        chk("bp_fires", 128'(n_fire), 128'd2);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        // Simultaneous accept and release with both stages full
        out_ready = 1'b1; in_state = rnd128(); cyc();
        chk("sim_in_fire", 128'(last_fire), 128'd1);
        chk("sim_out_fire", 128'(last_ofire), 128'd1);
        out_ready = 1'b0; in_valid = 1'b0; cyc();
        chk("sim_full_out", 128'(out_valid), 128'd1);
        chk("sim_full_in", 128'(in_ready), 128'd0);
        drain();

        // in_first mid-block at round 4
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_first = (i == 0 || i == 4); in_state = rnd128(); cyc();
        end
        chk("mid_first_rc", 128'(rc_m), 128'd4);
        drain();

        // Reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1; in_first = 1'b1;
        cyc(); in_first = 1'b0; cyc(); cyc();
        in_valid = 1'b0; rst = 1'b1; cyc();
        chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
        chk("rst_mid_in_ready", 128'(in_ready), 128'd0);
        rst = 1'b0; in_valid = 1'b1; in_state = rnd128(); cyc();
        chk("rst_mid_round0", 128'(q[0].rnd), 128'd0);
        drain();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_first  = ($urandom_range(0, 14) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_state  = rnd128();
            if ($urandom_range(0, 99) == 0) rk_mem[$urandom_range(11, 15)] = rnd128();
            cyc();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
